// File: rtl/lfsr_pkg.sv
// Shared types and defaults for the lfsr generator/checker pair.
package lfsr_pkg;

    localparam int LFSR_LEN = 8;
    localparam logic [LFSR_LEN-1:0] LFSR_TAPS = 8'b1011_1000;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lfsr_checker_state_t;

endpackage

// File: rtl/lfsr_checker_if.sv
// Received word stream feeding lfsr_checker: source drives, checker samples.
interface lfsr_checker_if
    import lfsr_pkg::*;
#(
    parameter int LEN = LFSR_LEN
) ();

    logic           in_valid;
    logic [LEN-1:0] in_data;

    modport master (output in_valid, output in_data);
    modport slave  (input  in_valid, input  in_data);

endinterface

// File: rtl/lfsr_next.sv
// Galois LFSR step, bit-identical to the generator: shift right, XOR taps on bit 0.
module lfsr_next #(
    parameter int             LEN  = 8,
    parameter logic [LEN-1:0] TAPS = 8'b1011_1000
) (
    input  logic [LEN-1:0] v_i,
    output logic [LEN-1:0] next_o
);

    assign next_o = {1'b0, v_i[LEN-1:1]} ^ (v_i[0] ? TAPS : '0);

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising LFSR stream checker: HUNT -> VERIFY -> LOCKED, counts locked mismatches.
// Optional word counter built when LFSR_CHECKER_WORD_COUNT_EN is defined.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int             LEN        = LFSR_LEN,
    parameter logic [LEN-1:0] TAPS       = LFSR_TAPS,
    parameter int             LOCK_COUNT = 16,
    parameter int             LOSS_COUNT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    lfsr_checker_if.slave        in_if,
    input  logic                 clear_counts_i,
    output logic                 locked_o,
    output logic                 error_o,
    output logic [15:0]          error_count_o,
    output logic [1:0]           state_o,
    output logic [31:0]          word_count_o
);

    localparam int RUN_MAX = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam logic [RUN_W-1:0] LOCK_CMP = LOCK_COUNT[RUN_W-1:0];
    localparam logic [RUN_W-1:0] LOSS_CMP = LOSS_COUNT[RUN_W-1:0];

    lfsr_checker_state_t state_q;
    logic [LEN-1:0]      expected_q;
    logic [RUN_W-1:0]    run_q;
    logic                locked_q;
    logic                error_q;
    logic [15:0]         err_cnt_q, err_cnt_d;

    logic [LEN-1:0]      seed_nxt, exp_nxt;
    logic [RUN_W-1:0]    run_inc;
    logic                data_nz, match, in_locked;

    lfsr_next #(.LEN(LEN), .TAPS(TAPS)) u_next_in  (.v_i(in_if.in_data), .next_o(seed_nxt));
    lfsr_next #(.LEN(LEN), .TAPS(TAPS)) u_next_exp (.v_i(expected_q),    .next_o(exp_nxt));

    assign data_nz   = |in_if.in_data;
    assign match     = (in_if.in_data == expected_q);
    assign run_inc   = run_q + 1'b1;
    assign in_locked = in_if.in_valid && (state_q == LOCKED);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= HUNT;
            expected_q <= '0;
            run_q      <= '0;
            locked_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            error_q <= 1'b0;
            if (in_if.in_valid) begin
                case (state_q)
                    HUNT: begin
                        // Zero never appears in a live LFSR stream, so it cannot seed.
                        if (data_nz) begin
                            expected_q <= seed_nxt;
                            run_q      <= '0;
                            state_q    <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (match) begin
                            expected_q <= exp_nxt;
                            if (run_inc == LOCK_CMP) begin
                                run_q    <= '0;
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                run_q <= run_inc;
                            end
                        end else if (data_nz) begin
                            expected_q <= seed_nxt;
                            run_q      <= '0;
                        end else begin
                            run_q   <= '0;
                            state_q <= HUNT;
                        end
                    end
                    LOCKED: begin
                        // Freewheel: once locked the predictor never reseeds from data.
                        expected_q <= exp_nxt;
                        if (match) begin
                            run_q <= '0;
                        end else begin
                            error_q <= 1'b1;
                            if (run_inc == LOSS_CMP) begin
                                run_q    <= '0;
                                state_q  <= HUNT;
                                locked_q <= 1'b0;
                            end else begin
                                run_q <= run_inc;
                            end
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        run_q    <= '0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A clear coinciding with an increment leaves the counter at 1.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clear_counts_i)
            err_cnt_d = {15'd0, in_locked && !match};
        else if (in_locked && !match && err_cnt_q != 16'hFFFF)
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

`ifdef LFSR_CHECKER_WORD_COUNT_EN
    logic [31:0] wrd_cnt_q, wrd_cnt_d;

    always_comb begin
        wrd_cnt_d = wrd_cnt_q;
        if (clear_counts_i)
            wrd_cnt_d = {31'd0, in_locked};
        else if (in_locked && wrd_cnt_q != 32'hFFFF_FFFF)
            wrd_cnt_d = wrd_cnt_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) wrd_cnt_q <= '0;
        else       wrd_cnt_q <= wrd_cnt_d;
    end

    assign word_count_o = wrd_cnt_q;
`else
    assign word_count_o = '0;
`endif

    assign locked_o      = locked_q;
    assign error_o       = error_q;
    assign error_count_o = err_cnt_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed-vector bench for lfsr_checker (LEN=8, TAPS=B8, LOCK_COUNT=4, LOSS_COUNT=2).
module tb_lfsr_checker;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear_counts;
    logic        locked, error;
    logic [15:0] error_count;
    logic [1:0]  state;
    logic [31:0] word_count;

    int vecs = 0;
    int errs = 0;

    // Hand-expanded stream from seed FF: v' = (v>>1) ^ (v[0] ? B8 : 0)
    localparam logic [7:0] SEQ [19] = '{
        8'hFF, 8'hC7, 8'hDB, 8'hD5, 8'hD2, 8'h69, 8'h8C, 8'h46, 8'h23, 8'hA9,
        8'hEC, 8'h76, 8'h3B, 8'hA5, 8'hEA, 8'h75, 8'h82, 8'h41, 8'h98
    };

`ifdef LFSR_CHECKER_WORD_COUNT_EN
    localparam logic [31:0] WC10 = 32'd10;
`else
    localparam logic [31:0] WC10 = 32'd0;
`endif

    lfsr_checker_if #(.LEN(8)) bus ();

    lfsr_checker #(
        .LEN(8), .TAPS(8'hB8), .LOCK_COUNT(4), .LOSS_COUNT(2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_if         (bus),
        .clear_counts_i(clear_counts),
        .locked_o      (locked),
        .error_o       (error),
        .error_count_o (error_count),
        .state_o       (state),
        .word_count_o  (word_count)
    );

    always #5 clock = ~clock;

    task automatic step(input logic v, input logic [7:0] d, input logic clr);
        bus.in_valid = v;
        bus.in_data  = d;
        clear_counts = clr;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        clear_counts = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        clear_counts = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic lock_up();
        for (int i = 0; i < 5; i++) step(1'b1, SEQ[i], 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        vecs++; if (state !== 2'd0)        begin errs++; $display("FAIL reset_state: got %0d want 0", state); end
        vecs++; if (locked !== 1'b0)       begin errs++; $display("FAIL reset_locked: got %0b want 0", locked); end
        vecs++; if (error !== 1'b0)        begin errs++; $display("FAIL reset_error: got %0b want 0", error); end
        vecs++; if (error_count !== 16'd0) begin errs++; $display("FAIL reset_errcnt: got %0d want 0", error_count); end
        vecs++; if (word_count !== 32'd0)  begin errs++; $display("FAIL reset_wordcnt: got %0d want 0", word_count); end
    endtask

    task automatic test_clean_stream();
        do_reset();
        step(1'b1, 8'hFF, 1'b0);
        vecs++; if (state !== 2'd1) begin errs++; $display("FAIL clean_seed_state: got %0d want 1", state); end
        for (int i = 1; i < 4; i++) begin
            step(1'b1, SEQ[i], 1'b0);
            vecs++; if (locked !== 1'b0 || state !== 2'd1)
                begin errs++; $display("FAIL clean_verify_%0d: got locked=%0b state=%0d want 0/1", i, locked, state); end
        end
        step(1'b1, 8'hD2, 1'b0);
        vecs++; if (locked !== 1'b1 || state !== 2'd2)
            begin errs++; $display("FAIL clean_lock: got locked=%0b state=%0d want 1/2", locked, state); end
        step(1'b1, 8'h69, 1'b0);
        vecs++; if (locked !== 1'b1 || error !== 1'b0 || error_count !== 16'd0)
            begin errs++; $display("FAIL clean_locked_word: got locked=%0b err=%0b cnt=%0d want 1/0/0", locked, error, error_count); end
    endtask

    task automatic test_leading_zeros();
        do_reset();
        step(1'b1, 8'h00, 1'b0);
        vecs++; if (state !== 2'd0) begin errs++; $display("FAIL zeros_first: got %0d want 0", state); end
        step(1'b1, 8'h00, 1'b0);
        vecs++; if (state !== 2'd0) begin errs++; $display("FAIL zeros_second: got %0d want 0", state); end
        step(1'b1, 8'hFF, 1'b0);
        vecs++; if (state !== 2'd1) begin errs++; $display("FAIL zeros_seed: got %0d want 1", state); end
        step(1'b1, 8'hC7, 1'b0);
        vecs++; if (state !== 2'd1 || dut.run_q !== 3'd1)
            begin errs++; $display("FAIL zeros_run: got state=%0d run=%0d want 1/1", state, dut.run_q); end
    endtask

    task automatic test_single_error();
        do_reset();
        lock_up();
        step(1'b1, SEQ[5], 1'b0);
        step(1'b1, 8'h00, 1'b0);
        vecs++; if (error !== 1'b1 || error_count !== 16'd1 || locked !== 1'b1)
            begin errs++; $display("FAIL single_err: got err=%0b cnt=%0d locked=%0b want 1/1/1", error, error_count, locked); end
        step(1'b0, 8'h00, 1'b0);
        vecs++; if (error !== 1'b0 || state !== 2'd2)
            begin errs++; $display("FAIL gap_hold: got err=%0b state=%0d want 0/2", error, state); end
        step(1'b1, SEQ[7], 1'b0);
        vecs++; if (error !== 1'b0 || error_count !== 16'd1 || locked !== 1'b1)
            begin errs++; $display("FAIL single_recover: got err=%0b cnt=%0d locked=%0b want 0/1/1", error, error_count, locked); end
    endtask

    task automatic test_loss();
        do_reset();
        lock_up();
        step(1'b1, 8'h00, 1'b0);
        vecs++; if (locked !== 1'b1 || error_count !== 16'd1)
            begin errs++; $display("FAIL loss_first: got locked=%0b cnt=%0d want 1/1", locked, error_count); end
        step(1'b1, 8'h00, 1'b0);
        vecs++; if (locked !== 1'b0 || state !== 2'd0 || error_count !== 16'd2 || error !== 1'b1)
            begin errs++; $display("FAIL loss_drop: got locked=%0b state=%0d cnt=%0d err=%0b want 0/0/2/1", locked, state, error_count, error); end
    endtask

    task automatic test_clear_same_cycle();
        do_reset();
        lock_up();
        // Alternate wrong/right so five errors accumulate without losing lock.
        for (int k = 5; k <= 13; k++)
            step(1'b1, (k % 2 == 1) ? (SEQ[k] ^ 8'h01) : SEQ[k], 1'b0);
        vecs++; if (error_count !== 16'd5 || locked !== 1'b1)
            begin errs++; $display("FAIL clear_pre: got cnt=%0d locked=%0b want 5/1", error_count, locked); end
        step(1'b1, SEQ[14], 1'b0);
        step(1'b1, SEQ[15] ^ 8'h01, 1'b1);
        vecs++; if (error_count !== 16'd1 || error !== 1'b1)
            begin errs++; $display("FAIL clear_with_inc: got cnt=%0d err=%0b want 1/1", error_count, error); end
        step(1'b1, SEQ[16], 1'b1);
        vecs++; if (error_count !== 16'd0 || locked !== 1'b1)
            begin errs++; $display("FAIL clear_plain: got cnt=%0d locked=%0b want 0/1", error_count, locked); end
    endtask

    task automatic test_word_count();
        do_reset();
        lock_up();
        vecs++; if (word_count !== 32'd0) begin errs++; $display("FAIL wc_at_lock: got %0d want 0", word_count); end
        for (int k = 5; k < 15; k++) step(1'b1, SEQ[k], 1'b0);
        vecs++; if (word_count !== WC10) begin errs++; $display("FAIL wc_ten: got %0d want %0d", word_count, WC10); end
    endtask

    task automatic test_reset_mid_locked();
        do_reset();
        lock_up();
        step(1'b1, 8'h00, 1'b0);
        reset = 1'b1;
        step(1'b1, 8'h00, 1'b0);
        reset = 1'b0;
        vecs++; if (state !== 2'd0 || locked !== 1'b0 || error !== 1'b0 || error_count !== 16'd0 || word_count !== 32'd0)
            begin errs++; $display("FAIL reset_mid: got state=%0d locked=%0b err=%0b cnt=%0d wc=%0d want all 0",
                                   state, locked, error, error_count, word_count); end
    endtask

    initial begin
        reset = 1'b1;
        clear_counts = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_clean_stream();
        test_leading_zeros();
        test_single_error();
        test_loss();
        test_clear_same_cycle();
        test_word_count();
        test_reset_mid_locked();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
